// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative multiply/divide unit with architectural HI/LO.
//
// Runs MULT/MULTU/DIV/DIVU as 32 radix-2 steps followed by one sign-fix
// cycle, so Busy is high for 33 cycles per operation. MTHI/MTLO write HI/LO
// in a single cycle without leaving IDLE.
//
// Build option: define MULDIV_DIV_EN to include the restoring divider.
// Without it, DIV/DIVU requests are ignored like NOP.
//
// Ports:
//   clk    in  rising-edge clock
//   rstn   in  asynchronous active-low reset
//   A      in  rs operand (multiplicand / dividend / MTHI-MTLO source)
//   B      in  rt operand (multiplier / divisor)
//   MDOp   in  operation select (0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//              5 MTHI, 6 MTLO, 7 reserved = NOP)
//   Start  in  single-cycle request qualifying MDOp/A/B
//   Busy   out high while an iterative operation is in flight
//   Done   out one-cycle pulse in the cycle after HI/LO are written
//   HI     out HI register
//   LO     out LO register
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       MDOp,
   input  logic             Start,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

   state_t state, state_nxt;
   logic [4:0] cnt;

   // Two's-complement negate when neg is set.
   function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v,
                                                   input logic neg);
      return neg ? ({WIDTH{1'b0}} - v) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v,
                                                      input logic neg);
      return neg ? ({(2*WIDTH){1'b0}} - v) : v;
   endfunction

   // ---------------------------------------------------------------- request
   logic start_mul, start_div, start_mthi, start_mtlo, start_iter;

   always_comb begin
      start_mul  = 1'b0;
      start_div  = 1'b0;
      start_mthi = 1'b0;
      start_mtlo = 1'b0;
      if (Start && state == IDLE) begin
         case (MDOp)
            MD_MULT, MD_MULTU: start_mul = 1'b1;
`ifdef MULDIV_DIV_EN
            MD_DIV, MD_DIVU:   start_div = 1'b1;
`else
            MD_DIV, MD_DIVU:   ;  // divider not built: request is a no-op
`endif
            MD_MTHI:           start_mthi = 1'b1;
            MD_MTLO:           start_mtlo = 1'b1;
            default:           ;
         endcase
      end
   end

   assign start_iter = start_mul | start_div;

   logic signed [WIDTH-1:0] a_s, b_s;
   logic                    signed_op, a_neg_in, b_neg_in;
   logic [WIDTH-1:0]        a_mag_in, b_mag_in;

   assign a_s       = A;
   assign b_s       = B;
   assign signed_op = (MDOp == MD_MULT) || (MDOp == MD_DIV);
   assign a_neg_in  = signed_op && (a_s < 0);
   assign b_neg_in  = signed_op && (b_s < 0);
   assign a_mag_in  = cond_neg_w(A, a_neg_in);
   assign b_mag_in  = cond_neg_w(B, b_neg_in);

   // ---------------------------------------------------------------- datapath
   // acc holds {partial product high, multiplier bits} for multiply and
   // {partial remainder, dividend/quotient bits} for divide.
   logic [2*WIDTH-1:0] acc, acc_step;
   logic [WIDTH-1:0]   a_mag;
   logic               res_neg;    // product or quotient sign
   logic [WIDTH:0]     mul_sum;
`ifdef MULDIV_DIV_EN
   logic [WIDTH-1:0]   b_mag;
   logic               is_div, rem_neg, div_zero;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_rem;
   logic               div_ge;
`endif

   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                 {1'b0, (acc[0] ? a_mag : {WIDTH{1'b0}})};
      acc_step = {mul_sum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
      // Restoring step: shift in the next dividend bit, subtract if it fits.
      // The remainder stays below the divisor, so 32 bits hold it afterwards.
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, b_mag});
      div_rem   = div_shift[WIDTH-1:0] - b_mag;
      if (is_div)
         acc_step = {(div_ge ? div_rem : div_shift[WIDTH-1:0]),
                     acc[WIDTH-2:0], div_ge};
`endif
   end

   always_ff @(posedge clk) begin
      if (start_iter) begin
         a_mag   <= a_mag_in;
         res_neg <= a_neg_in ^ b_neg_in;
         acc     <= {{WIDTH{1'b0}}, (start_div ? a_mag_in : b_mag_in)};
`ifdef MULDIV_DIV_EN
         b_mag    <= b_mag_in;
         is_div   <= start_div;
         rem_neg  <= a_neg_in;
         div_zero <= (B == {WIDTH{1'b0}});
`endif
      end else if (state == CALC) begin
         acc <= acc_step;
      end
   end

   // ---------------------------------------------------------------- fix-up
   logic [WIDTH-1:0] fix_hi, fix_lo;

   always_comb begin
      {fix_hi, fix_lo} = cond_neg_2w(acc, res_neg);
`ifdef MULDIV_DIV_EN
      if (is_div) begin
         if (div_zero) begin
            // Divide by zero: all-ones quotient, dividend as remainder.
            fix_lo = {WIDTH{1'b1}};
            fix_hi = cond_neg_w(a_mag, rem_neg);
         end else begin
            fix_lo = cond_neg_w(acc[WIDTH-1:0], res_neg);
            fix_hi = cond_neg_w(acc[2*WIDTH-1:WIDTH], rem_neg);
         end
      end
`endif
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_iter) state_nxt = CALC;
         CALC:    if (cnt == 5'd31) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      Busy = (state != IDLE);
   end

   // ---------------------------------------------------------------- control / HI-LO
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt  <= 5'd0;
         Done <= 1'b0;
         HI   <= {WIDTH{1'b0}};
         LO   <= {WIDTH{1'b0}};
      end else begin
         Done <= (state == FIX);
         if (start_iter)
            cnt <= 5'd0;
         else if (state == CALC)
            cnt <= cnt + 5'd1;
         if (state == FIX) begin
            HI <= fix_hi;
            LO <= fix_lo;
         end else if (start_mthi) begin
            HI <= A;
         end else if (start_mtlo) begin
            LO <= A;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed self-checking bench for muldiv_unit.
// Covers reset, signed/unsigned multiply, divide (when MULDIV_DIV_EN is
// defined, otherwise checks that divide requests are ignored), MTHI/MTLO,
// ignored requests while busy, NOP/reserved codes and reset mid-operation.
module tb_muldiv_unit;

   localparam logic [2:0] MD_NOP   = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;
   localparam logic [2:0] MD_RSVD  = 3'd7;
`ifdef MULDIV_DIV_EN
   localparam logic [2:0] ABORT_OP = MD_DIV;
`else
   localparam logic [2:0] ABORT_OP = MD_MULT;
`endif

   logic        clk = 1'b0;
   logic        rstn;
   logic        Start;
   logic [2:0]  MDOp;
   logic [31:0] A, B;
   logic        Busy, Done;
   logic [31:0] HI, LO;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_hi = 32'h0;
   logic [31:0] exp_lo = 32'h0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .A     (A),
      .B     (B),
      .MDOp  (MDOp),
      .Start (Start),
      .Busy  (Busy),
      .Done  (Done),
      .HI    (HI),
      .LO    (LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Drive a request for one edge (E0); returns at E0+1 with operands scrambled.
   task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      Start = 1'b1;
      MDOp  = op;
      A     = a;
      B     = b;
      @(posedge clk);
      #1;
      Start = 1'b0;
      MDOp  = MD_NOP;
      A     = ~a;
      B     = ~b;
   endtask

   // Count edges since E0 until Busy drops; expect 33, results, one Done pulse.
   task automatic wait_done(input string tag, input int already,
                            input logic [31:0] eh, input logic [31:0] el);
      int n;
      int dn;
      n  = already;
      dn = 0;
      while (Busy === 1'b1 && n < 100) begin
         if (Done !== 1'b0) dn++;
         @(posedge clk);
         #1;
         n++;
      end
      exp_hi = eh;
      exp_lo = el;
      check($sformatf("%s busy_cycles", tag), n, 32'd33);
      check($sformatf("%s done_while_busy", tag), dn, 32'd0);
      check($sformatf("%s hi", tag), HI, exp_hi);
      check($sformatf("%s lo", tag), LO, exp_lo);
      check($sformatf("%s done_pulse", tag), {31'd0, Done}, 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("%s done_clear", tag), {31'd0, Done}, 32'd0);
   endtask

   // A request that must have no effect at all.
   task automatic expect_ignored(input string tag, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
      int bz;
      int dn;
      bz = 0;
      dn = 0;
      start_op(op, a, b);
      repeat (36) begin
         if (Busy !== 1'b0) bz++;
         if (Done !== 1'b0) dn++;
         @(posedge clk);
         #1;
      end
      check($sformatf("%s busy", tag), bz, 32'd0);
      check($sformatf("%s done", tag), dn, 32'd0);
      check($sformatf("%s hi", tag), HI, exp_hi);
      check($sformatf("%s lo", tag), LO, exp_lo);
   endtask

   task automatic move_to(input string tag, input logic [2:0] op, input logic [31:0] v);
      start_op(op, v, 32'h0);
      if (op == MD_MTHI) exp_hi = v;
      else               exp_lo = v;
      check($sformatf("%s hi", tag), HI, exp_hi);
      check($sformatf("%s lo", tag), LO, exp_lo);
      check($sformatf("%s busy", tag), {31'd0, Busy}, 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("%s no_done", tag), {31'd0, Done}, 32'd0);
   endtask

   initial begin
      int dn;
      int bz;
      rstn  = 1'b1;
      Start = 1'b0;
      MDOp  = MD_NOP;
      A     = 32'h0;
      B     = 32'h0;
      #2 rstn = 1'b0;
      #1;
      check("reset hi", HI, 32'h0);
      check("reset lo", LO, 32'h0);
      check("reset busy", {31'd0, Busy}, 32'd0);
      check("reset done", {31'd0, Done}, 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // Multiply
      start_op(MD_MULT, 32'hFFFFFFFD, 32'd7);
      wait_done("mult_m3x7", 0, 32'hFFFFFFFF, 32'hFFFFFFEB);
      start_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done("multu_max", 0, 32'hFFFFFFFE, 32'h00000001);
      start_op(MD_MULT, 32'h7FFFFFFF, 32'h80000000);
      wait_done("mult_maxpos_minneg", 0, 32'hC0000000, 32'h80000000);
      start_op(MD_MULT, 32'h80000000, 32'h80000000);
      wait_done("mult_minneg_sq", 0, 32'h40000000, 32'h00000000);

      // Moves and ignored codes
      move_to("mthi", MD_MTHI, 32'hCAFEBABE);
      move_to("mtlo", MD_MTLO, 32'h0BADF00D);
      expect_ignored("nop", MD_NOP, 32'h11111111, 32'h2);
      expect_ignored("reserved", MD_RSVD, 32'h22222222, 32'h3);

      // Divide
`ifdef MULDIV_DIV_EN
      start_op(MD_DIV, 32'hFFFFFFF9, 32'd2);
      wait_done("div_m7_2", 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
      start_op(MD_DIVU, 32'd7, 32'd0);
      wait_done("divu_by0", 0, 32'h00000007, 32'hFFFFFFFF);
      start_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_done("div_overflow", 0, 32'h00000000, 32'h80000000);
      start_op(MD_DIV, 32'd100, 32'hFFFFFFF9);
      wait_done("div_100_m7", 0, 32'h00000002, 32'hFFFFFFF2);
      start_op(MD_DIVU, 32'hFFFFFFFF, 32'h10);
      wait_done("divu_max_16", 0, 32'h0000000F, 32'h0FFFFFFF);
      start_op(MD_DIV, 32'hFFFFFFFB, 32'd0);
      wait_done("div_m5_by0", 0, 32'hFFFFFFFB, 32'hFFFFFFFF);
`else
      expect_ignored("div_disabled", MD_DIV, 32'h80000000, 32'hFFFFFFFF);
      expect_ignored("divu_disabled", MD_DIVU, 32'd7, 32'd0);
`endif

      // Requests while busy are dropped
      start_op(MD_MULT, 32'd6, 32'd7);
      @(negedge clk);
      Start = 1'b1; MDOp = MD_MTLO; A = 32'h1234;
      @(posedge clk);
      #1;
      Start = 1'b0; MDOp = MD_NOP;
      check("mtlo_while_busy lo", LO, exp_lo);
      @(negedge clk);
      Start = 1'b1; MDOp = MD_MULT; A = 32'd3; B = 32'd3;
      @(posedge clk);
      #1;
      Start = 1'b0; MDOp = MD_NOP;
      wait_done("mult_busy_ignore", 2, 32'h0, 32'd42);
      move_to("mtlo_after", MD_MTLO, 32'h1234);

      // Reset mid-operation
      move_to("mthi_pre_abort", MD_MTHI, 32'h55AA55AA);
      start_op(ABORT_OP, 32'd50, 32'd7);
      repeat (10) @(posedge clk);
      #1 rstn = 1'b0;
      #1;
      exp_hi = 32'h0;
      exp_lo = 32'h0;
      check("abort hi", HI, exp_hi);
      check("abort lo", LO, exp_lo);
      check("abort busy", {31'd0, Busy}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      dn = 0;
      bz = 0;
      repeat (40) begin
         if (Done !== 1'b0) dn++;
         if (Busy !== 1'b0) bz++;
         @(posedge clk);
         #1;
      end
      check("abort no_done", dn, 32'd0);
      check("abort stays_idle", bz, 32'd0);
      check("abort hi_held", HI, exp_hi);
      check("abort lo_held", LO, exp_lo);
      start_op(MD_MULT, 32'd5, 32'hFFFFFFFC);
      wait_done("mult_after_abort", 0, 32'hFFFFFFFF, 32'hFFFFFFEC);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
